// File: rtl/usr_shift_sequencer.sv
// Command sequencer driving a universal shift register: optional parallel load followed by
// N serial shifts with LSB-first fill. Optional abort input enabled by USR_SEQ_ABORT_EN.

// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | mode=11, parallel_in carries the load value for one cycle
// SHIFT | one shift per cycle, fill[0] on the active serial pin
// DONE  | mode=00, done pulse, returns to IDLE next cycle
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_fill,
`ifdef USR_SEQ_ABORT_EN
    input  logic             cmd_abort,
`endif
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] parallel_in,
    output logic             serial_in_left,
    output logic             serial_in_right,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic             dir_left;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] fill;
    logic             abort_req;
    logic             src_left;
    logic [CNT_W-1:0] src_cnt;
    logic [WIDTH-1:0] src_fill;
    logic             go_shift;

`ifdef USR_SEQ_ABORT_EN
    assign abort_req = cmd_abort;
`else
    assign abort_req = 1'b0;
`endif

    // A shift can start straight from IDLE, so take its operands from the command bus there.
    always_comb begin
        src_left = dir_left;
        src_cnt  = cnt;
        src_fill = fill;
        if (state == IDLE) begin
            src_left = cmd_op[0];
            src_cnt  = cmd_count;
            src_fill = cmd_fill;
        end
        go_shift = ((state == IDLE) && cmd_valid && cmd_ready && !cmd_op[1] && (cmd_count != '0))
                || (((state == LOAD) || (state == SHIFT)) && !abort_req && (cnt != '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            dir_left        <= 1'b0;
            cnt             <= '0;
            fill            <= '0;
            mode            <= 2'b00;
            parallel_in     <= '0;
            serial_in_left  <= 1'b0;
            serial_in_right <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cmd_ready       <= 1'b1;
        end else begin
            parallel_in     <= '0;
            serial_in_left  <= 1'b0;
            serial_in_right <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        dir_left  <= cmd_op[0];
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (cmd_op[1]) begin
                            state       <= LOAD;
                            mode        <= 2'b11;
                            parallel_in <= cmd_data;
                            cnt         <= cmd_count;
                            fill        <= cmd_fill;
                        end else if (cmd_count == '0) begin
                            state <= DONE;
                            mode  <= 2'b00;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD, SHIFT: begin
                    if (abort_req || (cnt == '0)) begin
                        state <= DONE;
                        mode  <= 2'b00;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    mode      <= 2'b00;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (go_shift) begin
                state           <= SHIFT;
                mode            <= src_left ? 2'b10 : 2'b01;
                serial_in_left  <= !src_left && src_fill[0];
                serial_in_right <= src_left && src_fill[0];
                fill            <= src_fill >> 1;
                cnt             <= src_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer driving a 4-bit shift register; directed cases plus random
// commands checked against a command-level model. Abort case needs USR_SEQ_ABORT_EN.
module tb_usr_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_count;
    logic [3:0] cmd_fill;
    logic [1:0] mode;
    logic [3:0] parallel_in;
    logic       serial_in_left;
    logic       serial_in_right;
    logic       busy;
    logic       done;
`ifdef USR_SEQ_ABORT_EN
    logic       cmd_abort;
`endif

    logic [3:0]  q;
    logic [3:0]  m_q;
    int          n_vec = 0;
    int          n_err = 0;
    // per-cycle trace: {mode, parallel_in, sil, sir, done, busy, cmd_ready}
    logic [10:0] obs_vec[$];
    logic [3:0]  obs_q[$];

    always #5 clk = ~clk;

    usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .cmd_count(cmd_count),
        .cmd_fill(cmd_fill),
`ifdef USR_SEQ_ABORT_EN
        .cmd_abort(cmd_abort),
`endif
        .mode(mode),
        .parallel_in(parallel_in),
        .serial_in_left(serial_in_left),
        .serial_in_right(serial_in_right),
        .busy(busy),
        .done(done)
    );

    // downstream universal shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= 4'b0000;
        else begin
            case (mode)
                2'b01:   q <= {serial_in_left, q[3:1]};
                2'b10:   q <= {q[2:0], serial_in_right};
                2'b11:   q <= parallel_in;
                default: q <= q;
            endcase
        end
    end

    function automatic logic [3:0] model_q(input logic [3:0] q0, input logic [1:0] op,
                                           input logic [3:0] data, input int cnt,
                                           input logic [3:0] fill);
        logic [3:0] r;
        logic       b;
        r = op[1] ? data : q0;
        for (int i = 0; i < cnt; i++) begin
            b = (i < 4) ? fill[i[1:0]] : 1'b0;
            r = op[0] ? {r[2:0], b} : {b, r[3:1]};
        end
        return r;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                           input logic [3:0] fill, output int lat);
        int guard;
        guard = 0;
        obs_vec.delete();
        obs_q.delete();
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wait got ready=%b exp 1", cmd_ready);
        end
        cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_fill = fill; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            obs_vec.push_back({mode, parallel_in, serial_in_left, serial_in_right, done, busy, cmd_ready});
            obs_q.push_back(q);
        end while (!done && lat < 20);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_vec++;
        if ({mode, parallel_in, serial_in_left, serial_in_right, busy, done, q} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs got mode=%b pin=%b sl=%b sr=%b busy=%b done=%b q=%b exp all 0",
                     mode, parallel_in, serial_in_left, serial_in_right, busy, done, q);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release got ready/busy/done=%b exp 100", {cmd_ready, busy, done});
        end
        m_q = 4'b0000;
    endtask

    task automatic test_load_shift_right();
        int         lat;
        logic [3:0] exp_q[3] = '{4'b1010, 4'b1101, 4'b1110};
        run_cmd(2'b10, 4'b1010, 3'd2, 4'b0011, lat);
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL t1_latency got %0d exp 4", lat);
        end
        for (int k = 1; k <= 3; k++) begin
            n_vec++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k-1]) begin
                n_err++;
                $display("FAIL t1_q[%0d] got %b exp %b", k, (k < obs_q.size()) ? obs_q[k] : 4'bx, exp_q[k-1]);
            end
        end
        m_q = model_q(m_q, 2'b10, 4'b1010, 2, 4'b0011);
    endtask

    task automatic test_load_shift_left();
        int         lat;
        logic [1:0] exp_m[5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [3:0] exp_q[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        run_cmd(2'b11, 4'b0001, 3'd3, 4'b0000, lat);
        n_vec++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL t2_latency got %0d exp 5", lat);
        end
        for (int k = 0; k < 5 && k < lat; k++) begin
            n_vec++;
            if (obs_vec[k][10:9] !== exp_m[k]) begin
                n_err++;
                $display("FAIL t2_mode[%0d] got %b exp %b", k, obs_vec[k][10:9], exp_m[k]);
            end
        end
        for (int k = 1; k < 5 && k < lat; k++) begin
            n_vec++;
            if (obs_q[k] !== exp_q[k-1]) begin
                n_err++;
                $display("FAIL t2_q[%0d] got %b exp %b", k, obs_q[k], exp_q[k-1]);
            end
        end
        m_q = model_q(m_q, 2'b11, 4'b0001, 3, 4'b0000);
    endtask

    task automatic test_fill_exhaust();
        int   lat;
        logic exp_sl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        run_cmd(2'b10, 4'b1111, 3'd6, 4'b0101, lat);
        n_vec++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL t3_latency got %0d exp 8", lat);
        end
        for (int k = 1; k <= 6 && k < lat; k++) begin
            n_vec++;
            if (obs_vec[k][4:3] !== {exp_sl[k-1], 1'b0}) begin
                n_err++;
                $display("FAIL t3_serial[%0d] got sl/sr=%b exp %b", k, obs_vec[k][4:3], {exp_sl[k-1], 1'b0});
            end
        end
        n_vec++;
        if (q !== 4'b0001) begin
            n_err++;
            $display("FAIL t3_final_q got %b exp 0001", q);
        end
        m_q = 4'b0001;
    endtask

    task automatic test_back_to_back();
        logic [2:0] s[4];
        logic [2:0] exp_s[4] = '{3'b110, 3'b001, 3'b110, 3'b001};
        @(negedge clk);
        cmd_op = 2'b00; cmd_count = 3'd0; cmd_data = 4'b1111; cmd_fill = 4'b1111; cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s[k] = {done, busy, cmd_ready};
            if (k == 2) cmd_valid = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (s[k] !== exp_s[k]) begin
                n_err++;
                $display("FAIL b2b_cycle%0d got done/busy/ready=%b exp %b", k + 1, s[k], exp_s[k]);
            end
        end
        n_vec++;
        if (q !== m_q) begin
            n_err++;
            $display("FAIL b2b_q got %b exp %b", q, m_q);
        end
    endtask

    task automatic test_reset_midcmd();
        logic saw_done;
        @(negedge clk);
        while (!cmd_ready) @(negedge clk);
        cmd_op = 2'b10; cmd_data = 4'b1010; cmd_count = 3'd2; cmd_fill = 4'b0011; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({mode, busy, serial_in_left, serial_in_right, q} !== 8'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got mode=%b busy=%b sl=%b sr=%b q=%b exp all 0",
                     mode, busy, serial_in_left, serial_in_right, q);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        reset_n = 1'b1;
        @(negedge clk);
        saw_done = saw_done | done;
        n_vec++;
        if ({cmd_ready, saw_done} !== 2'b10) begin
            n_err++;
            $display("FAIL midreset_release got ready=%b done_seen=%b exp ready=1 done_seen=0", cmd_ready, saw_done);
        end
        m_q = 4'b0000;
    endtask

    task automatic test_random();
        int          lat, exp_lat, ld, s;
        logic [1:0]  op;
        logic [3:0]  data, fill;
        logic [2:0]  cnt;
        logic        b;
        logic [10:0] e;
        for (int n = 0; n < 30; n++) begin
            op   = 2'($urandom_range(0, 3));
            data = 4'($urandom);
            fill = 4'($urandom);
            cnt  = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(op, data, cnt, fill, lat);
            ld      = op[1] ? 1 : 0;
            exp_lat = 1 + ld + int'(cnt);
            n_vec++;
            if (lat !== exp_lat) begin
                n_err++;
                $display("FAIL rnd%0d_latency got %0d exp %0d (op=%b cnt=%0d)", n, lat, exp_lat, op, cnt);
            end
            for (int j = 0; j < lat && j < exp_lat; j++) begin
                s = j - ld;
                if (ld == 1 && j == 0) e = {2'b11, data, 2'b00, 3'b010};
                else if (j < exp_lat - 1) begin
                    b = (s < 4) ? fill[s[1:0]] : 1'b0;
                    e = {(op[0] ? 2'b10 : 2'b01), 4'b0000, !op[0] && b, op[0] && b, 3'b010};
                end else e = {2'b00, 4'b0000, 2'b00, 3'b110};
                n_vec++;
                if (obs_vec[j] !== e) begin
                    n_err++;
                    $display("FAIL rnd%0d_cycle%0d got %b exp %b (mode,pin,sl,sr,done,busy,ready)", n, j, obs_vec[j], e);
                end
            end
            m_q = model_q(m_q, op, data, int'(cnt), fill);
            n_vec++;
            if (q !== m_q) begin
                n_err++;
                $display("FAIL rnd%0d_q got %b exp %b", n, q, m_q);
            end
        end
    endtask

`ifdef USR_SEQ_ABORT_EN
    task automatic test_abort();
        @(negedge clk);
        while (!cmd_ready) @(negedge clk);
        cmd_op = 2'b10; cmd_data = 4'b1111; cmd_count = 3'd6; cmd_fill = 4'b0101; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        n_vec++;
        if ({done, mode, q} !== 7'b1_00_0111) begin
            n_err++;
            $display("FAIL abort_stop got done=%b mode=%b q=%b exp done=1 mode=00 q=0111", done, mode, q);
        end
        @(negedge clk);
        n_vec++;
        if ({cmd_ready, done, q} !== 6'b10_0111) begin
            n_err++;
            $display("FAIL abort_idle got ready=%b done=%b q=%b exp 1 0 0111", cmd_ready, done, q);
        end
        m_q = 4'b0111;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'b0; cmd_count = 3'd0; cmd_fill = 4'b0;
`ifdef USR_SEQ_ABORT_EN
        cmd_abort = 1'b0;
`endif
        test_reset();
        test_load_shift_right();
        test_load_shift_left();
        test_fill_exhaust();
        test_back_to_back();
        test_reset_midcmd();
        test_random();
`ifdef USR_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
